generic_rom_streamer: RTL and testbench



---
 rtl/generic_rom_streamer.sv | 208 ++++++++++++++++++++
 tb/tb_generic_rom_streamer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/generic_rom_streamer.sv
// generic_rom_streamer: turns the fixed-latency address-in/data-out port of
// generic_rom into a valid/ready stream. A start command walks i_len words
// from i_start_addr. Addresses are issued only while the in-flight reads plus
// the buffered words fit in the output FIFO, so back-pressure never drops data.
//
// Optional feature macro: GENERIC_ROM_STREAMER_ABORT_EN adds i_abort, which
// cancels a running transfer, flushes the pipe and FIFO and pulses o_done.
module generic_rom_streamer #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 10,
  parameter int READ_LATENCY  = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [ADDRESS_WIDTH-1:0] i_start_addr,
  input  logic [ADDRESS_WIDTH:0]   i_len,
`ifdef GENERIC_ROM_STREAMER_ABORT_EN
  input  logic                     i_abort,
`endif
  output logic                     o_busy,
  output logic                     o_done,
  output logic [ADDRESS_WIDTH-1:0] o_rom_address,
  input  logic [DATA_WIDTH-1:0]    i_rom_data,
  output logic                     o_valid,
  output logic [DATA_WIDTH-1:0]    o_data,
  output logic                     o_last,
  input  logic                     i_ready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(READ_LATENCY + 1);
  localparam int SW = $clog2(FIFO_DEPTH + READ_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t                   r_state;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [ADDRESS_WIDTH:0]   r_remaining;
  logic                     r_busy;
  logic                     r_done;

  // In-flight read tracking: one valid bit and one last bit per ROM stage.
  logic [READ_LATENCY-1:0]  r_pipe_vld;
  logic [READ_LATENCY-1:0]  r_pipe_last;

  // Output FIFO storage and bookkeeping.
  logic [DATA_WIDTH-1:0]    r_mem_data [FIFO_DEPTH];
  logic                     r_mem_last [FIFO_DEPTH];
  logic [PW-1:0]            r_wr_ptr;
  logic [PW-1:0]            r_rd_ptr;
  logic [CW-1:0]            r_count;

  logic [IW-1:0]            w_inflight;
  logic [SW-1:0]            w_used;
  logic                     w_abort;
  logic                     w_issue;
  logic                     w_issue_last;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_valid;
  logic                     w_head_last;

`ifdef GENERIC_ROM_STREAMER_ABORT_EN
  assign w_abort = i_abort && (r_state != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  // Count outstanding ROM reads so credit covers words not yet in the FIFO.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      w_inflight = w_inflight + IW'(r_pipe_vld[i]);
    end
  end

  assign w_used       = SW'(w_inflight) + SW'(r_count);
  assign w_issue      = (r_state == S_RUN) && !w_abort && (w_used < SW'(FIFO_DEPTH));
  assign w_issue_last = w_issue && (r_remaining == (ADDRESS_WIDTH + 1)'(1));
  assign w_push       = r_pipe_vld[READ_LATENCY-1] && !w_abort;
  assign w_valid      = (r_count != '0);
  assign w_pop        = w_valid && i_ready && !w_abort;
  assign w_head_last  = r_mem_last[r_rd_ptr];

  // Outputs come from FIFO registers; masking keeps them at zero while empty.
  assign o_valid       = w_valid;
  assign o_data        = w_valid ? r_mem_data[r_rd_ptr] : '0;
  assign o_last        = w_valid ? w_head_last : 1'b0;
  assign o_rom_address = r_addr;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Transfer sequencer: state, address walk, remaining count, busy/done.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples its pre-edge inputs regardless of statement order.
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state     <= S_RUN;
              r_addr      <= i_start_addr;
              r_remaining <= i_len;
              r_busy      <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_issue) begin
            r_addr      <= r_addr + 1'b1;
            r_remaining <= r_remaining - 1'b1;
            if (w_issue_last) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_abort || (w_pop && w_head_last)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Shift issue/last markers alongside the ROM's internal read pipeline.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pipe_vld  <= '0;
      r_pipe_last <= '0;
    end else if (w_abort) begin
      r_pipe_vld  <= '0;
      r_pipe_last <= '0;
    end else begin
      r_pipe_vld[0]  <= w_issue;
      r_pipe_last[0] <= w_issue_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_last[i] <= r_pipe_last[i-1];
      end
    end
  end

  // FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage writes as ROM data emerges from the read pipeline.
  always_ff @(posedge i_clk) begin
    // NOTE: storage is not reset; an entry is only read after it was written,
    // and the empty-masking above keeps the outputs at zero until then.
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= i_rom_data;
      r_mem_last[r_wr_ptr] <= r_pipe_last[READ_LATENCY-1];
    end
  end

endmodule

// File: tb/tb_generic_rom_streamer.sv
// Self-checking bench for generic_rom_streamer: a two-stage ROM model feeds
// the DUT, expected words are queued at start and compared as they stream out.
module tb_generic_rom_streamer;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int RL = 2;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   len = '0;
  logic          ready = 1'b1;
  logic          busy, done, valid, last;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data, data;
`ifdef GENERIC_ROM_STREAMER_ABORT_EN
  logic          abort = 1'b0;
`endif

  generic_rom_streamer #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(RL), .FIFO_DEPTH(FD)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (i_start),
    .i_start_addr (start_addr),
    .i_len        (len),
`ifdef GENERIC_ROM_STREAMER_ABORT_EN
    .i_abort      (abort),
`endif
    .o_busy       (busy),
    .o_done       (done),
    .o_rom_address(rom_addr),
    .i_rom_data   (rom_data),
    .o_valid      (valid),
    .o_data       (data),
    .o_last       (last),
    .i_ready      (ready)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {6'h2B, a, ~a, 6'h15};
  endfunction

  // ROM model: address register then output register.
  logic [AW-1:0] rom_addr_q;
  always @(posedge clk) begin
    rom_addr_q <= rom_addr;
    rom_data   <= rom_word(rom_addr_q);
  end

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_acc    = 0;
  bit ready_toggle = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Downstream ready: held high, or toggled every cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ready = ready_toggle ? ~ready : 1'b1;
    end
  end

  // Monitor: pop the scoreboard on each handshake, check stall stability.
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(valid), 64'(1));
        check("hold_data", 64'({last, data}), 64'({prev_last, prev_data}));
      end
      if (valid && ready) begin
        check("sb_has_word", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("data", 64'(data), 64'(e.data));
          check("last", 64'(last), 64'(e.last));
        end
        n_acc++;
      end
      prev_stall = valid && !ready;
      prev_data  = data;
      prev_last  = last;
    end
  end

  task automatic check_reset_outputs();
    check("rst_addr",  64'(rom_addr), 64'(0));
    check("rst_valid", 64'(valid),    64'(0));
    check("rst_data",  64'(data),     64'(0));
    check("rst_last",  64'(last),     64'(0));
    check("rst_busy",  64'(busy),     64'(0));
    check("rst_done",  64'(done),     64'(0));
  endtask

  // Pulse start for one edge and queue the expected words; returns #1 after it.
  task automatic start_xfer(input logic [AW-1:0] a, input int l);
    logic [AW-1:0] wa;
    @(posedge clk);
    #1;
    i_start    = 1'b1;
    start_addr = a;
    len        = (AW + 1)'(l);
    for (int i = 0; i < l; i++) begin
      wa = a + AW'(i);
      exp_q.push_back('{last: (i == l - 1), data: rom_word(wa)});
    end
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic run_xfer(input logic [AW-1:0] a, input int l, input bit tog, input int restart_at);
    bit got_done = 1'b0;
    ready_toggle = tog;
    start_xfer(a, l);
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 1) check("busy_rise", 64'(busy), 64'(l != 0));
      if (k == restart_at) begin
        i_start    = 1'b1;
        start_addr = 10'h055;
        len        = 11'd3;
      end
      if (k == restart_at + 1) i_start = 1'b0;
      if (done) begin
        got_done = 1'b1;
        if (!tog) check("done_latency", 64'(k), 64'((l == 0) ? 1 : l + RL + 2));
        check("busy_low_at_done", 64'(busy), 64'(0));
        break;
      end
    end
    check("done_seen", 64'(got_done), 64'(1));
    check("sb_empty", 64'(exp_q.size()), 64'(0));
    @(negedge clk);
    check("done_pulse", 64'(done), 64'(0));
    ready_toggle = 1'b0;
  endtask

  task automatic wait_words(input int n, input string tag);
    bit reached = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (n_acc >= n) begin
        reached = 1'b1;
        break;
      end
    end
    check(tag, 64'(reached), 64'(1));
  endtask

  initial begin
    bit seen_valid;
    int n0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_xfer(10'h010, 8, 1'b0, -1);
    run_xfer(10'h010, 8, 1'b1, -1);
    run_xfer(10'h3FE, 4, 1'b0, -1);
    run_xfer(10'h000, 0, 1'b0, -1);
    run_xfer(10'h100, 16, 1'b0, 5);

    // Asynchronous reset after the third word of a ten-word transfer.
    n0 = n_acc;
    start_xfer(10'h120, 10);
    wait_words(n0 + 3, "reach_3_words");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (valid) seen_valid = 1'b1;
    end
    check("no_valid_after_rst", 64'(seen_valid), 64'(0));
    check("idle_after_rst", 64'({busy, done}), 64'(0));
    run_xfer(10'h200, 5, 1'b0, -1);

`ifdef GENERIC_ROM_STREAMER_ABORT_EN
    n0 = n_acc;
    start_xfer(10'h080, 10);
    wait_words(n0 + 2, "reach_2_words");
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b0;
    check("abort_valid", 64'(valid), 64'(0));
    check("abort_done",  64'(done),  64'(1));
    check("abort_busy",  64'(busy),  64'(0));
    exp_q.delete();
    @(negedge clk);
    check("abort_done_pulse", 64'(done), 64'(0));
    run_xfer(10'h300, 2, 1'b0, -1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
